// File: rtl/demux_dispatch_pkg.sv
// Shared types for the demux dispatch controller.
package demux_dispatch_pkg;

  // Controller state: no word held, or one word held until its destination accepts it.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage : demux_dispatch_pkg

// File: rtl/demux_dispatch_demux.sv
// Recursive 1-to-2**S demultiplexer. The MSB of ctrl picks the upper or lower
// half, and the remaining bits select within that half. Every slice that is not
// selected is driven to zero.
module recurse_demux #(
  parameter int S = 2,
  parameter int T = 1
) (
  input  logic [S-1:0]         ctrl,
  input  logic [T-1:0]         in,
  output logic [(2**S)*T-1:0]  out
);

  localparam int HALF = (2**(S-1)) * T;

  generate
    if (S == 1) begin : g_leaf
      // Two-way split on the single remaining select bit.
      always_comb begin
        // NOTE: the default assignment keeps this combinational block from inferring a latch.
        out = '0;
        if (ctrl[0]) begin
          out[2*T-1:T] = in;
        end else begin
          out[T-1:0]   = in;
        end
      end
    end else begin : g_node
      logic [T-1:0] lo_in;
      logic [T-1:0] hi_in;

      // Route the word to one half; the other half receives zero.
      always_comb begin
        lo_in = ctrl[S-1] ? '0 : in;
        hi_in = ctrl[S-1] ? in : '0;
      end

      recurse_demux #(.S(S-1), .T(T)) u_lo (
        .ctrl (ctrl[S-2:0]),
        .in   (lo_in),
        .out  (out[HALF-1:0])
      );

      recurse_demux #(.S(S-1), .T(T)) u_hi (
        .ctrl (ctrl[S-2:0]),
        .in   (hi_in),
        .out  (out[2*HALF-1:HALF])
      );
    end
  endgenerate

endmodule : recurse_demux

// File: rtl/demux_dispatch.sv
// Demux dispatch controller. It accepts words on a valid/ready input and holds
// each word until the destination picked by round-robin or an explicit address
// takes it. The held word is presented through a recurse_demux, and a second
// 1-bit demux builds the one-hot valid vector.
module demux_dispatch
  import demux_dispatch_pkg::*;
#(
  parameter int S = 2,
  parameter int T = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [T-1:0]            in_data,
  input  logic                    mode,
  input  logic [S-1:0]            addr,
  output logic [(2**S)-1:0]       out_valid,
  input  logic [(2**S)-1:0]       out_ready,
  output logic [(2**S)*T-1:0]     out_data,
  output logic [S-1:0]            sel,
  output logic [S-1:0]            rr_ptr
);

  localparam int N = 2**S;

  state_t        state;
  logic [T-1:0]  hold;
  logic          held_rr;   // the held word was targeted round-robin
  logic          deliver;
  logic          accept;
  logic          advance;
  logic [S-1:0]  rr_next;
  logic [0:0]    busy;

  // Delivery, acceptance and the post-delivery round-robin pointer.
  // in_ready depends only on state and out_ready, so in_valid never reaches it.
  always_comb begin
    deliver  = (state == HOLD) && out_ready[sel];
    in_ready = (state == IDLE) || out_ready[sel];
    accept   = in_valid && in_ready;
    advance  = deliver && held_rr;
    rr_next  = advance ? rr_ptr + S'(1) : rr_ptr;
    busy     = (state == HOLD);
  end

  // Control FSM: load a word and its target on accept, release it on delivery.
  // An accept in the same cycle as a delivery uses the already advanced pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here has a defined reset value. Reset clears a held
    // word completely, so no partial delivery can follow a mid-transfer reset.
    if (!rst_n) begin
      state   <= IDLE;
      hold    <= '0;
      held_rr <= 1'b0;
      sel     <= '0;
      rr_ptr  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register sample pre-edge values.
      rr_ptr <= rr_next;
      if (accept) begin
        state   <= HOLD;
        hold    <= in_data;
        sel     <= mode ? addr : rr_next;
        held_rr <= ~mode;
      end else if (deliver) begin
        state   <= IDLE;
      end
    end
  end

  // Data path: the held word appears only on the selected slice.
  recurse_demux #(.S(S), .T(T)) u_data_demux (
    .ctrl (sel),
    .in   (hold),
    .out  (out_data)
  );

  // Valid path: one-hot valid while a word is held, all zero when idle.
  recurse_demux #(.S(S), .T(1)) u_valid_demux (
    .ctrl (sel),
    .in   (busy),
    .out  (out_valid)
  );

endmodule : demux_dispatch

// File: tb/tb_demux_dispatch.sv
// Testbench for demux_dispatch (S=2, T=4). A transaction-level model predicts
// every output on each falling edge. Directed literal checks pin the model at
// the key points of each scenario.
module tb_demux_dispatch;

  localparam int S = 2;
  localparam int T = 4;
  localparam int N = 2**S;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [T-1:0]    in_data;
  logic            mode;
  logic [S-1:0]    addr;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [N*T-1:0]  out_data;
  logic [S-1:0]    sel;
  logic [S-1:0]    rr_ptr;

  int vectors;
  int miscompares;

  demux_dispatch #(.S(S), .T(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .addr      (addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .rr_ptr    (rr_ptr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: one slot that is either empty or holds a word bound for a target.
  bit        m_busy;
  int        m_word;
  int        m_target;
  bit        m_word_rr;
  int        m_rr;

  always @(posedge clk or negedge rst_n) begin
    bit delivered;
    if (!rst_n) begin
      m_busy    = 0;
      m_word    = 0;
      m_target  = 0;
      m_word_rr = 0;
      m_rr      = 0;
    end else begin
      delivered = m_busy && out_ready[m_target];
      if (delivered && m_word_rr) m_rr = (m_rr + 1) % N;
      if ((!m_busy || delivered) && in_valid) begin
        m_busy    = 1;
        m_word    = int'(in_data);
        m_target  = mode ? int'(addr) : m_rr;
        m_word_rr = !mode;
      end else if (delivered) begin
        m_busy = 0;
      end
    end
  end

  // Compare the DUT against the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("m_in_ready", 32'(in_ready), 32'(!m_busy || out_ready[m_target]));
      check("m_out_valid", 32'(out_valid), m_busy ? (32'd1 << m_target) : 32'd0);
      check("m_sel", 32'(sel), 32'(m_target));
      check("m_rr_ptr", 32'(rr_ptr), 32'(m_rr));
      if (m_busy) check("m_out_data", 32'(out_data), 32'(m_word) << (m_target * T));
    end
  end

  task automatic drive(input logic v, input logic [T-1:0] d, input logic m,
                       input logic [S-1:0] a, input logic [N-1:0] r);
    in_valid  = v;
    in_data   = d;
    mode      = m;
    addr      = a;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    drive(0, 4'h0, 0, 2'd0, 4'b0000);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_sel", 32'(sel), 32'h0);
    check("reset_rr_ptr", 32'(rr_ptr), 32'h0);
    check("reset_out_data", 32'(out_data), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Reset in the middle of a hold.
    drive(1, 4'h1, 0, 2'd0, 4'b0000);
    tick();
    check("hold_valid", 32'(out_valid), 32'b0001);
    drive(0, 4'h0, 0, 2'd0, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_sel", 32'(sel), 32'h0);
    check("async_rst_rr", 32'(rr_ptr), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Round-robin sweep at full throughput.
    drive(1, 4'h1, 0, 2'd0, 4'b1111);
    tick(); check("rr0", 32'(out_valid), 32'b0001); check("rr_in_ready0", 32'(in_ready), 32'h1);
    tick(); check("rr1", 32'(out_valid), 32'b0010);
    tick(); check("rr2", 32'(out_valid), 32'b0100);
    tick(); check("rr3", 32'(out_valid), 32'b1000); check("rr_ptr3", 32'(rr_ptr), 32'd3);
    tick(); check("rr4", 32'(out_valid), 32'b0001); check("rr_wrap", 32'(rr_ptr), 32'd0);
    drive(0, 4'h0, 0, 2'd0, 4'b1111);
    tick(); check("rr_idle", 32'(out_valid), 32'h0); check("rr_after", 32'(rr_ptr), 32'd1);

    // Addressed routing leaves the pointer alone.
    drive(1, 4'h1, 1, 2'd2, 4'b1111);
    tick();
    check("addr_valid", 32'(out_valid), 32'b0100);
    check("addr_data", 32'(out_data), 32'h0100);
    check("addr_rr", 32'(rr_ptr), 32'd1);
    drive(1, 4'h1, 0, 2'd0, 4'b1101);
    tick();
    check("after_addr_target", 32'(out_valid), 32'b0010);

    // Backpressure on target 1 with changing inputs.
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'(i + 7), 1, 2'(i), 4'b1101);
      #1 check("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("bp_valid", 32'(out_valid), 32'b0010);
      check("bp_data", 32'(out_data), 32'h0010);
    end
    drive(0, 4'h0, 0, 2'd0, 4'b0010);
    tick();
    check("bp_done_valid", 32'(out_valid), 32'h0);
    check("bp_done_rr", 32'(rr_ptr), 32'd2);

    // Delivery and acceptance in the same cycle while the next target stalls.
    drive(1, 4'h3, 0, 2'd0, 4'b1111);
    tick();
    check("b2b_first", 32'(out_valid), 32'b0100);
    drive(1, 4'h9, 0, 2'd0, 4'b0100);
    tick();
    check("b2b_second", 32'(out_valid), 32'b1000);
    check("b2b_sel", 32'(sel), 32'd3);
    drive(0, 4'h0, 0, 2'd0, 4'b0100);
    tick(); tick();
    check("b2b_stall_valid", 32'(out_valid), 32'b1000);
    check("b2b_stall_data", 32'(out_data), 32'h9000);
    drive(0, 4'h0, 0, 2'd0, 4'b1000);
    tick();
    check("b2b_done", 32'(out_valid), 32'h0);
    check("b2b_rr_wrap", 32'(rr_ptr), 32'd0);

    // Data integrity with addressed 4-bit words.
    drive(1, 4'hA, 1, 2'd3, 4'b1111);
    tick(); check("di_a", 32'(out_data), 32'hA000);
    drive(1, 4'h5, 1, 2'd0, 4'b1111);
    tick(); check("di_5", 32'(out_data), 32'h0005);
    drive(1, 4'hF, 1, 2'd2, 4'b1111);
    tick(); check("di_f", 32'(out_data), 32'h0F00);
    drive(0, 4'h0, 0, 2'd0, 4'b1111);
    tick(); check("di_idle", 32'(out_valid), 32'h0); check("di_rr", 32'(rr_ptr), 32'd0);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_demux_dispatch
